// File: rtl/exe_stage_mc.sv
// exe_stage_mc -- execute stage with an iterative multiplier.
//
// The ALU operands are chosen from the register operands, the immediate, or the
// shift amount. Single-cycle ALU ops finish in one cycle. MUL runs a shift-add
// loop. The result and the EXE control bits are registered into the EXE/MEM
// pipeline register.
//
// Ports
//   clk, clrn            clock; synchronous active-high reset
//   exe_valid/exe_flush  instruction present in EXE / kill it
//   ea, eb, eimm         register operands and extended immediate
//   ealuc                ALU op: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 LUI 9 MUL
//   ealuimm, eshift      alub = eimm instead of eb; alua = shift amount instead of ea
//   exe_wreg/m2reg/wmem  control bits carried to MEM
//   exe_d                destination register
//   stall                EXE busy; upstream must hold its inputs
//   ealu, z              combinational EXE result (forwarding source), ealu==0
//   mem_*, S, MEM_Alu    EXE/MEM pipeline register
module exe_stage_mc #(
  parameter int WIDTH = 32,
  parameter int RA    = 5,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             exe_valid,
  input  logic             exe_flush,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic [WIDTH-1:0] eimm,
  input  logic [3:0]       ealuc,
  input  logic             ealuimm,
  input  logic             eshift,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic             exe_wmem,
  input  logic [RA-1:0]    exe_d,
  output logic             stall,
  output logic [WIDTH-1:0] ealu,
  output logic             z,
  output logic             mem_valid,
  output logic             mem_wreg,
  output logic             mem_m2reg,
  output logic             mem_wmem,
  output logic [RA-1:0]    mem_d,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] MEM_Alu
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] alua, alub, alu_res;
  logic [WIDTH-1:0] mcand, mplr, acc, acc_step;
  logic [CW-1:0]    cnt;
  logic             start, load_v;

  assign alua = eshift ? {{(WIDTH-SHW){1'b0}}, eimm[SHW+4:5]} : ea;
  assign alub = ealuimm ? eimm : eb;

  // MUL returns 0 here; the product comes from the iterative unit in DONE.
  always_comb begin
    alu_res = '0;
    case (ealuc)
      4'd0: alu_res = alua + alub;
      4'd1: alu_res = alua - alub;
      4'd2: alu_res = alua & alub;
      4'd3: alu_res = alua | alub;
      4'd4: alu_res = alua ^ alub;
      4'd5: alu_res = alub << alua[SHW-1:0];
      4'd6: alu_res = alub >> alua[SHW-1:0];
      4'd7: alu_res = WIDTH'($signed(alub) >>> alua[SHW-1:0]);
      4'd8: alu_res = alub << (WIDTH/2);
      default: alu_res = '0;
    endcase
  end

  // One shift-add step. The register loop runs WIDTH-1 steps in MUL. The last
  // step is applied combinationally in DONE, so the product appears without an
  // extra cycle.
  assign acc_step = acc + (mplr[0] ? mcand : '0);

  assign start = (state == IDLE) && exe_valid && (ealuc == 4'd9) && !exe_flush;

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    ealu     = alu_res;
    case (state)
      IDLE: if (start) begin
        state_nx = MUL;
        stall    = 1'b1;
      end
      MUL: begin
        stall = 1'b1;
        ealu  = '0;
        if (cnt == CW'(2)) state_nx = DONE;
      end
      DONE: begin
        ealu     = acc_step;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Flush wins over start and DONE: the partial product is simply abandoned.
    if (exe_flush) begin
      state_nx = IDLE;
      stall    = 1'b0;
    end
  end

  assign z      = (ealu == '0);
  assign load_v = exe_valid && !exe_flush && !stall;

  always_ff @(posedge clk) begin
    if (clrn) begin
      state <= IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        mcand <= alua;
        mplr  <= alub;
        acc   <= '0;
        cnt   <= CW'(WIDTH);
      end else if (state == MUL) begin
        acc   <= acc_step;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        cnt   <= cnt - 1'b1;
      end
    end
  end

  // EXE/MEM register. Bubbles clear only the control bits; the data fields
  // still load, and nothing downstream reads them while mem_valid is 0.
  always_ff @(posedge clk) begin
    if (clrn) begin
      mem_valid <= 1'b0;
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
      mem_wmem  <= 1'b0;
      mem_d     <= '0;
      S         <= '0;
      MEM_Alu   <= '0;
    end else begin
      mem_valid <= load_v;
      mem_wreg  <= load_v & exe_wreg;
      mem_m2reg <= load_v & exe_m2reg;
      mem_wmem  <= load_v & exe_wmem;
      mem_d     <= exe_d;
      S         <= eb;
      MEM_Alu   <= ealu;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc. A WIDTH=32 instance is checked through a scoreboard
// of expected EXE/MEM loads. A WIDTH=8 instance is checked for the multiply
// and add-wrap cases.
module tb_exe_stage_mc;

  logic        clk, clrn;
  logic        exe_valid, exe_flush, ealuimm, eshift, exe_wreg, exe_m2reg, exe_wmem;
  logic [31:0] ea, eb, eimm;
  logic [3:0]  ealuc;
  logic [4:0]  exe_d;
  logic        stall, z, mem_valid, mem_wreg, mem_m2reg, mem_wmem;
  logic [31:0] ealu, S, MEM_Alu;
  logic [4:0]  mem_d;

  logic        b_valid, b_stall, b_z, b_mem_valid, b_mem_wreg, b_mem_m2reg, b_mem_wmem;
  logic [7:0]  b_ea, b_eb, b_ealu, b_S, b_MEM_Alu;
  logic [3:0]  b_ealuc;
  logic [4:0]  b_mem_d;

  exe_stage_mc #(.WIDTH(32), .RA(5)) dut (
    .clk(clk), .clrn(clrn), .exe_valid(exe_valid), .exe_flush(exe_flush),
    .ea(ea), .eb(eb), .eimm(eimm), .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem), .exe_d(exe_d),
    .stall(stall), .ealu(ealu), .z(z), .mem_valid(mem_valid), .mem_wreg(mem_wreg),
    .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem), .mem_d(mem_d), .S(S), .MEM_Alu(MEM_Alu)
  );

  exe_stage_mc #(.WIDTH(8), .RA(5)) dut8 (
    .clk(clk), .clrn(clrn), .exe_valid(b_valid), .exe_flush(1'b0),
    .ea(b_ea), .eb(b_eb), .eimm(8'h00), .ealuc(b_ealuc), .ealuimm(1'b0), .eshift(1'b0),
    .exe_wreg(1'b1), .exe_m2reg(1'b0), .exe_wmem(1'b0), .exe_d(5'd3),
    .stall(b_stall), .ealu(b_ealu), .z(b_z), .mem_valid(b_mem_valid), .mem_wreg(b_mem_wreg),
    .mem_m2reg(b_mem_m2reg), .mem_wmem(b_mem_wmem), .mem_d(b_mem_d), .S(b_S), .MEM_Alu(b_MEM_Alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, w, m2, wm;
    logic [4:0]  d;
    logic [31:0] s, alu;
  } mem_exp_t;

  mem_exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sweep_exp [0:8] = '{32'hFFFFFFFF, 32'h0000001F, 32'h00000000,
                                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFF00,
                                   32'h0FFFFFFF, 32'hFFFFFFFF, 32'h12340000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void exp_bubble();
    mem_exp_t e;
    e = '{v:1'b0, w:1'b0, m2:1'b0, wm:1'b0, d:5'd0, s:32'd0, alu:32'd0};
    sb.push_back(e);
  endfunction

  function automatic void exp_load(input logic [31:0] alu);
    mem_exp_t e;
    e = '{v:1'b1, w:exe_wreg, m2:exe_m2reg, wm:exe_wmem, d:exe_d, s:eb, alu:alu};
    sb.push_back(e);
  endfunction

  // One clock edge; then compare the MEM load against the oldest expectation.
  task automatic tick();
    mem_exp_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_underflow t=%0t", $time);
    end else begin
      e = sb.pop_front();
      chk("mem_valid", mem_valid, e.v);
      chk("mem_wreg",  mem_wreg,  e.w);
      chk("mem_m2reg", mem_m2reg, e.m2);
      chk("mem_wmem",  mem_wmem,  e.wm);
      if (e.v) begin
        chk("mem_d",   mem_d,   e.d);
        chk("S",       S,       e.s);
        chk("MEM_Alu", MEM_Alu, e.alu);
      end
    end
  endtask

  task automatic idle_tick();
    exp_bubble();
    tick();
  endtask

  // Issue a MUL and follow it through: WIDTH stalled bubble cycles, then DONE.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int stop_at);
    logic [31:0] p;
    p = a * b;
    ea = a; eb = b; ealuc = 4'd9; eshift = 0; ealuimm = 0; exe_valid = 1;
    exe_wreg = 1; exe_m2reg = 0; exe_wmem = 0; exe_d = 5'd7;
    for (int k = 0; k < 32; k++) begin
      if (k == stop_at) return;
      #1 chk("mul_stall", stall, 1'b1);
      idle_tick();
    end
    #1 chk("mul_done_stall", stall, 1'b0);
    chk("mul_done_ealu", ealu, p);
    exp_load(p);
    tick();
  endtask

  initial begin
    clrn = 1; exe_flush = 0; b_valid = 0; b_ea = 0; b_eb = 0; b_ealuc = 0;
    exe_valid = 1; ea = $urandom; eb = $urandom; eimm = $urandom;
    ealuc = 4'($urandom_range(0, 15)); ealuimm = 1'($urandom); eshift = 1'($urandom);
    exe_wreg = 1; exe_m2reg = 1; exe_wmem = 1; exe_d = 5'($urandom);

    // Reset with random inputs.
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_ctrl", {mem_wreg, mem_m2reg, mem_wmem}, 3'b000);
      chk("rst_mem_d", mem_d, 5'd0);
      chk("rst_S", S, 32'd0);
      chk("rst_MEM_Alu", MEM_Alu, 32'd0);
      chk("rst_b_mem_valid", b_mem_valid, 1'b0);
    end
    exe_valid = 0; clrn = 0;
    #1 chk("rst_stall", stall, 1'b0);

    // ALU sweep.
    for (int i = 0; i <= 8; i++) begin
      ea = 32'h0000000F; eb = 32'hFFFFFFF0; ealuc = 4'(i);
      eshift  = (i >= 5 && i <= 7);
      ealuimm = (i == 8);
      eimm    = (i == 8) ? 32'h1234 : (32'd4 << 5);
      exe_valid = 1; exe_wreg = 1; exe_m2reg = 1'(i); exe_wmem = 1'(i >> 1); exe_d = 5'(i + 1);
      #1 chk("alu_ealu", ealu, sweep_exp[i]);
      chk("alu_stall", stall, 1'b0);
      exp_load(sweep_exp[i]);
      tick();
    end

    // MUL then back-to-back MUL.
    run_mul(32'h0000FFFF, 32'h00010001, -1);
    run_mul(32'd3, 32'd7, -1);

    // Flush on the 10th cycle of a MUL, then an ADD.
    run_mul(32'd5, 32'd6, 9);
    exe_flush = 1;
    #1 chk("flush_stall", stall, 1'b0);
    idle_tick();
    exe_flush = 0; ea = 32'd2; eb = 32'd3; ealuc = 4'd0; exe_d = 5'd9;
    exp_load(32'd5);
    tick();

    // Reset on the 5th cycle of a MUL.
    run_mul(32'h0000FFFF, 32'h00010001, 4);
    clrn = 1; exe_valid = 0;
    idle_tick();
    chk("midrst_MEM_Alu", MEM_Alu, 32'd0);
    chk("midrst_S", S, 32'd0);
    chk("midrst_mem_d", mem_d, 5'd0);
    clrn = 0;
    for (int k = 0; k < 40; k++) begin
      #1 chk("midrst_stall", stall, 1'b0);
      idle_tick();
    end

    // WIDTH=8 instance: 0x0F*0x11 and ADD wrap.
    b_ea = 8'h0F; b_eb = 8'h11; b_ealuc = 4'd9; b_valid = 1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("w8_stall", b_stall, 1'b1);
      idle_tick();
      chk("w8_bubble", b_mem_valid, 1'b0);
    end
    #1 chk("w8_done_stall", b_stall, 1'b0);
    chk("w8_done_ealu", b_ealu, 8'hFF);
    idle_tick();
    chk("w8_mul_valid", b_mem_valid, 1'b1);
    chk("w8_mul_alu", b_MEM_Alu, 8'hFF);
    b_ea = 8'hFF; b_eb = 8'h01; b_ealuc = 4'd0;
    #1 chk("w8_z", b_z, 1'b1);
    chk("w8_add_ealu", b_ealu, 8'h00);
    idle_tick();
    chk("w8_add_valid", b_mem_valid, 1'b1);
    chk("w8_add_alu", b_MEM_Alu, 8'h00);
    b_valid = 0;

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_leftover count=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
